// File: rtl/cmd_regs_pkg.sv
// Shared definitions for the multi-channel command register bank:
// register offsets, packet type encoding and the per-channel header record.
package cmd_regs_pkg;

    // Global window offsets
    localparam logic [4:0] GOFS_ID     = 5'd0;
    localparam logic [4:0] GOFS_STATUS = 5'd1;
    localparam logic [4:0] GOFS_PEND   = 5'd2;

    // Channel window offsets
    localparam logic [4:0] OFS_CTRL        = 5'd0;
    localparam logic [4:0] OFS_SRC_MAC_HI  = 5'd10;
    localparam logic [4:0] OFS_SRC_MAC_LO  = 5'd11;
    localparam logic [4:0] OFS_DST_MAC_HI  = 5'd12;
    localparam logic [4:0] OFS_DST_MAC_LO  = 5'd13;
    localparam logic [4:0] OFS_SRC_IP      = 5'd14;
    localparam logic [4:0] OFS_DST_IP      = 5'd15;
    localparam logic [4:0] OFS_SRC_PORT    = 5'd16;
    localparam logic [4:0] OFS_DST_PORT    = 5'd17;
    localparam logic [4:0] OFS_PORTS       = 5'd18;
    localparam logic [4:0] OFS_UDP_LEN     = 5'd19;
    localparam logic [4:0] OFS_OPERATION   = 5'd20;
    localparam logic [4:0] OFS_THA_HI      = 5'd21;
    localparam logic [4:0] OFS_THA_LO      = 5'd22;
    localparam logic [4:0] OFS_TPA         = 5'd23;
    localparam logic [4:0] OFS_SHA_HI      = 5'd24;
    localparam logic [4:0] OFS_SHA_LO      = 5'd25;
    localparam logic [4:0] OFS_SPA         = 5'd26;

    typedef enum logic [1:0] {
        PKT_NONE = 2'd0,
        PKT_ARP  = 2'd1,
        PKT_UDP  = 2'd2,
        PKT_BOTH = 2'd3
    } pkt_type_t;

    // One channel's complete header configuration (shadow and active copies)
    typedef struct packed {
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_data_len;
        logic [1:0]  operation;
        logic [47:0] tha;
        logic [31:0] tpa;
        logic [47:0] sha;
        logic [31:0] spa;
    } chan_cfg_t;

    // Readback view of a channel record; unmapped offsets (including control) read 0
    function automatic logic [31:0] cfg_read(input chan_cfg_t cfg, input logic [4:0] ofs);
        logic [31:0] r;
        r = '0;
        case (ofs)
            OFS_SRC_MAC_HI: r = cfg.src_mac[47:16];
            OFS_SRC_MAC_LO: r = {16'd0, cfg.src_mac[15:0]};
            OFS_DST_MAC_HI: r = cfg.dst_mac[47:16];
            OFS_DST_MAC_LO: r = {16'd0, cfg.dst_mac[15:0]};
            OFS_SRC_IP:     r = cfg.src_ip;
            OFS_DST_IP:     r = cfg.dst_ip;
            OFS_SRC_PORT:   r = {16'd0, cfg.src_port};
            OFS_DST_PORT:   r = {16'd0, cfg.dst_port};
            OFS_PORTS:      r = {cfg.src_port, cfg.dst_port};
            OFS_UDP_LEN:    r = {16'd0, cfg.udp_data_len};
            OFS_OPERATION:  r = {30'd0, cfg.operation};
            OFS_THA_HI:     r = cfg.tha[47:16];
            OFS_THA_LO:     r = {16'd0, cfg.tha[15:0]};
            OFS_TPA:        r = cfg.tpa;
            OFS_SHA_HI:     r = cfg.sha[47:16];
            OFS_SHA_LO:     r = {16'd0, cfg.sha[15:0]};
            OFS_SPA:        r = cfg.spa;
            default:        r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_rr_arbiter.sv
// Combinational round-robin selector: first pending channel at or after
// rr_ptr, wrapping modulo N_CH.
module cmd_rr_arbiter #(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0] pending,
    input  logic [2:0]      rr_ptr,
    output logic [2:0]      gnt_ch,
    output logic            gnt_valid
);

    logic [3:0] cand;

    // Walk candidates in priority order starting at rr_ptr; the first hit wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(N_CH)) begin
                cand = cand - 4'(N_CH);
            end
            for (int j = 0; j < N_CH; j++) begin
                if (!gnt_valid && pending[j] && (cand == 4'(j))) begin
                    gnt_valid = 1'b1;
                    gnt_ch    = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cmd_regs_mc.sv
// Multi-channel command register bank. The host bus writes per-channel shadow
// header registers, commits them to active copies, and queues send requests;
// a round-robin arbiter hands one channel's active header to the packet engine
// over a req/ack handshake.
//
// Handshake: o_req rises with o_req_ch/o_req_type and all o_* header fields
// already valid; everything is held stable while o_req is high; the grant
// completes on the first rising edge where i_ack is sampled high, and o_req
// falls on that edge. o_req falling for any other reason (reset) is an abort.
module cmd_regs_mc
    import cmd_regs_pkg::*;
#(
    parameter int         N_CH    = 2,
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] VERSION = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [31:0]       i_cmd_data,
    input  logic              i_cmd_wr,
    input  logic              i_cmd_rd,
    output logic [31:0]       o_rd_data,
    output logic              o_rd_valid,
    output logic              o_req,
    output logic [2:0]        o_req_ch,
    output logic [1:0]        o_req_type,
    input  logic              i_ack,
    output logic [47:0]       o_dst_mac,
    output logic [47:0]       o_src_mac,
    output logic [1:0]        o_operation,
    output logic [47:0]       o_SHA,
    output logic [47:0]       o_THA,
    output logic [31:0]       o_SPA,
    output logic [31:0]       o_TPA,
    output logic [31:0]       o_src_ip,
    output logic [31:0]       o_dst_ip,
    output logic [15:0]       o_src_port,
    output logic [15:0]       o_dst_port,
    output logic [15:0]       o_udp_data_len,
    output logic [N_CH-1:0]   o_overflow
);

    localparam int WIN_W = ADDR_W - 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [WIN_W-1:0] win;
    logic [4:0]       ofs;
    logic             glob_sel;

    assign win      = i_cmd_addr[ADDR_W-1:5];
    assign ofs      = i_cmd_addr[4:0];
    assign glob_sel = (win == '0);

    chan_cfg_t shadow_q [N_CH];
    chan_cfg_t shadow_d [N_CH];
    chan_cfg_t active_q [N_CH];
    chan_cfg_t active_d [N_CH];
    pkt_type_t type_q   [N_CH];
    pkt_type_t type_d   [N_CH];

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] commit_pend_q, commit_pend_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [0:0]      state_q, state_d;
    logic            req_q, req_d;
    logic [2:0]      req_ch_q, req_ch_d;
    pkt_type_t       req_type_q, req_type_d;
    chan_cfg_t       out_q, out_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic [2:0] arb_ch;
    logic       arb_valid;

    cmd_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .pending   (pending_q),
        .rr_ptr    (rr_ptr_q),
        .gnt_ch    (arb_ch),
        .gnt_valid (arb_valid)
    );

    // Register writes, commit/send control and the grant FSM
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        type_d        = type_q;
        pending_d     = pending_q;
        commit_pend_d = commit_pend_q;
        overflow_d    = overflow_q;
        rr_ptr_d      = rr_ptr_q;
        state_d       = state_q;
        req_d         = req_q;
        req_ch_d      = req_ch_q;
        req_type_d    = req_type_q;
        out_d         = out_q;

        for (int c = 0; c < N_CH; c++) begin
            if (i_cmd_wr && (win == WIN_W'(c + 1))) begin
                case (ofs)
                    OFS_CTRL: begin
                        // A granted channel's active copy is frozen until ack
                        if (i_cmd_data[4]) begin
                            if ((state_q == ST_REQ) && (req_ch_q == 3'(c))) begin
                                commit_pend_d[c] = 1'b1;
                            end else begin
                                active_d[c] = shadow_q[c];
                            end
                        end
                        if (i_cmd_data[1:0] != 2'd0) begin
                            if (!pending_q[c] && !((state_q == ST_REQ) && (req_ch_q == 3'(c)))) begin
                                pending_d[c] = 1'b1;
                                type_d[c]    = pkt_type_t'(i_cmd_data[1:0]);
                            end else begin
                                overflow_d[c] = 1'b1;
                            end
                        end
                    end
                    OFS_SRC_MAC_HI: shadow_d[c].src_mac[47:16] = i_cmd_data;
                    OFS_SRC_MAC_LO: shadow_d[c].src_mac[15:0]  = i_cmd_data[15:0];
                    OFS_DST_MAC_HI: shadow_d[c].dst_mac[47:16] = i_cmd_data;
                    OFS_DST_MAC_LO: shadow_d[c].dst_mac[15:0]  = i_cmd_data[15:0];
                    OFS_SRC_IP:     shadow_d[c].src_ip         = i_cmd_data;
                    OFS_DST_IP:     shadow_d[c].dst_ip         = i_cmd_data;
                    OFS_SRC_PORT:   shadow_d[c].src_port       = i_cmd_data[15:0];
                    OFS_DST_PORT:   shadow_d[c].dst_port       = i_cmd_data[15:0];
                    OFS_PORTS: begin
                        shadow_d[c].src_port = i_cmd_data[31:16];
                        shadow_d[c].dst_port = i_cmd_data[15:0];
                    end
                    OFS_UDP_LEN:    shadow_d[c].udp_data_len   = i_cmd_data[15:0];
                    OFS_OPERATION:  shadow_d[c].operation      = i_cmd_data[1:0];
                    OFS_THA_HI:     shadow_d[c].tha[47:16]     = i_cmd_data;
                    OFS_THA_LO:     shadow_d[c].tha[15:0]      = i_cmd_data[15:0];
                    OFS_TPA:        shadow_d[c].tpa            = i_cmd_data;
                    OFS_SHA_HI:     shadow_d[c].sha[47:16]     = i_cmd_data;
                    OFS_SHA_LO:     shadow_d[c].sha[15:0]      = i_cmd_data[15:0];
                    OFS_SPA:        shadow_d[c].spa            = i_cmd_data;
                    default: ;
                endcase
            end
        end

        if (i_cmd_wr && glob_sel && (ofs == GOFS_STATUS) && i_cmd_data[0]) begin
            overflow_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d  = ST_REQ;
                    req_d    = 1'b1;
                    req_ch_d = arb_ch;
                    for (int c = 0; c < N_CH; c++) begin
                        if (arb_ch == 3'(c)) begin
                            out_d      = active_q[c];
                            req_type_d = type_q[c];
                        end
                    end
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    for (int c = 0; c < N_CH; c++) begin
                        if (req_ch_q == 3'(c)) begin
                            pending_d[c] = 1'b0;
                            rr_ptr_d     = (c == N_CH - 1) ? 3'd0 : 3'(c + 1);
                            // Deferred commit (possibly re-armed this very cycle)
                            if (commit_pend_d[c]) begin
                                active_d[c] = shadow_q[c];
                            end
                            commit_pend_d[c] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Readback mux, sampled from current register values (old value on same-cycle write)
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = i_cmd_rd;
        if (i_cmd_rd) begin
            if (glob_sel) begin
                case (ofs)
                    GOFS_ID:     rd_data_d = {16'd0, 8'(N_CH), VERSION};
                    GOFS_STATUS: rd_data_d = 32'(overflow_q);
                    GOFS_PEND:   rd_data_d = 32'(pending_q);
                    default:     rd_data_d = '0;
                endcase
            end
            for (int c = 0; c < N_CH; c++) begin
                if (win == WIN_W'(c + 1)) begin
                    rd_data_d = cfg_read(shadow_q[c], ofs);
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
                type_q[c]   <= PKT_NONE;
            end
            pending_q     <= '0;
            commit_pend_q <= '0;
            overflow_q    <= '0;
            rr_ptr_q      <= '0;
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            req_ch_q      <= '0;
            req_type_q    <= PKT_NONE;
            out_q         <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
                type_q[c]   <= type_d[c];
            end
            pending_q     <= pending_d;
            commit_pend_q <= commit_pend_d;
            overflow_q    <= overflow_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            req_q         <= req_d;
            req_ch_q      <= req_ch_d;
            req_type_q    <= req_type_d;
            out_q         <= out_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign o_rd_data      = rd_data_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_req          = req_q;
    assign o_req_ch       = req_ch_q;
    assign o_req_type     = req_type_q;
    assign o_overflow     = overflow_q;
    assign o_dst_mac      = out_q.dst_mac;
    assign o_src_mac      = out_q.src_mac;
    assign o_operation    = out_q.operation;
    assign o_SHA          = out_q.sha;
    assign o_THA          = out_q.tha;
    assign o_SPA          = out_q.spa;
    assign o_TPA          = out_q.tpa;
    assign o_src_ip       = out_q.src_ip;
    assign o_dst_ip       = out_q.dst_ip;
    assign o_src_port     = out_q.src_port;
    assign o_dst_port     = out_q.dst_port;
    assign o_udp_data_len = out_q.udp_data_len;

endmodule

// File: tb/tb_cmd_regs_mc.sv
// Bench for cmd_regs_mc (N_CH=2): readback scoreboard, register table,
// and hand-written grant/commit/overflow/reset sequences.
module tb_cmd_regs_mc;

  logic        clk;
  logic        rst;
  logic [7:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        i_cmd_wr;
  logic        i_cmd_rd;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_req;
  logic [2:0]  o_req_ch;
  logic [1:0]  o_req_type;
  logic        i_ack;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [1:0]  o_operation;
  logic [31:0] o_SPA, o_TPA, o_src_ip, o_dst_ip;
  logic [15:0] o_src_port, o_dst_port, o_udp_data_len;
  logic [1:0]  o_overflow;

  cmd_regs_mc #(.N_CH(2), .ADDR_W(8), .VERSION(8'h02)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .i_cmd_wr(i_cmd_wr), .i_cmd_rd(i_cmd_rd),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_req(o_req), .o_req_ch(o_req_ch), .o_req_type(o_req_type), .i_ack(i_ack),
    .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_operation(o_operation),
    .o_SHA(o_SHA), .o_THA(o_THA), .o_SPA(o_SPA), .o_TPA(o_TPA),
    .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip),
    .o_src_port(o_src_port), .o_dst_port(o_dst_port),
    .o_udp_data_len(o_udp_data_len), .o_overflow(o_overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // driver tasks: each starts 1 time unit after a rising edge and returns likewise
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    i_cmd_addr = a;
    i_cmd_data = d;
    i_cmd_wr   = 1'b1;
    step(1);
    i_cmd_wr   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    i_cmd_addr = a;
    i_cmd_rd   = 1'b1;
    exp_q.push_back(e);
    step(1);
    i_cmd_rd   = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
    i_cmd_addr = a;
    i_cmd_data = d;
    i_cmd_wr   = 1'b1;
    i_cmd_rd   = 1'b1;
    exp_q.push_back(e);
    step(1);
    i_cmd_wr   = 1'b0;
    i_cmd_rd   = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    step(1);
    i_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!o_req && n < 20) begin
      step(1);
      n++;
    end
    chk(name, 64'(o_req), 64'd1);
  endtask

  // scoreboard: every read-valid pulse pops one expected value
  always @(negedge clk) begin
    if (o_rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected act=%h exp=none", o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_rd_data !== mon_e) begin
          errors++;
          $display("FAIL rd_data act=%h exp=%h", o_rd_data, mon_e);
        end
      end
    end
  end

  initial begin
    int seen;
    rst = 1'b1; i_cmd_addr = '0; i_cmd_data = '0;
    i_cmd_wr = 1'b0; i_cmd_rd = 1'b0; i_ack = 1'b0;

    vecs[0]  = '{8'h4A, 32'hDEADBEEF, 8'h4A, 32'hDEADBEEF};
    vecs[1]  = '{8'h4B, 32'hFFFF1234, 8'h4B, 32'h00001234};
    vecs[2]  = '{8'h4C, 32'h01020304, 8'h4C, 32'h01020304};
    vecs[3]  = '{8'h4D, 32'h0000ABCD, 8'h4D, 32'h0000ABCD};
    vecs[4]  = '{8'h4F, 32'h0A000001, 8'h4F, 32'h0A000001};
    vecs[5]  = '{8'h52, 32'hAAAA5555, 8'h50, 32'h0000AAAA};
    vecs[6]  = '{8'h57, 32'hC0A80102, 8'h51, 32'h00005555};
    vecs[7]  = '{8'h54, 32'hFFFFFFFE, 8'h54, 32'h00000002};
    vecs[8]  = '{8'h55, 32'h11223344, 8'h52, 32'hAAAA5555};
    vecs[9]  = '{8'h56, 32'hFFFF5566, 8'h56, 32'h00005566};
    vecs[10] = '{8'h58, 32'h99887766, 8'h57, 32'hC0A80102};
    vecs[11] = '{8'h59, 32'h00007788, 8'h58, 32'h99887766};
    vecs[12] = '{8'h5A, 32'h0A0A0A0A, 8'h59, 32'h00007788};
    vecs[13] = '{8'h53, 32'h000105DC, 8'h53, 32'h000005DC};
    vecs[14] = '{8'h5B, 32'h12345678, 8'h5B, 32'h00000000};
    vecs[15] = '{8'h6E, 32'h12345678, 8'h6E, 32'h00000000};
    vecs[16] = '{8'h00, 32'hFFFFFFFF, 8'h00, 32'h00000202};
    vecs[17] = '{8'h02, 32'h000000FF, 8'h02, 32'h00000000};
    vecs[18] = '{8'h41, 32'h00000003, 8'h40, 32'h00000000};
    vecs[19] = '{8'h0E, 32'h55555555, 8'h5A, 32'h0A0A0A0A};

    step(3);
    rst = 1'b0;

    // 1. reset state
    chk("rst_ctrl", 64'({o_req, o_req_ch, o_req_type, o_overflow, o_rd_valid, o_operation}), 64'd0);
    chk("rst_fields", 64'(|{o_dst_mac, o_src_mac, o_SHA, o_THA, o_SPA, o_TPA, o_src_ip,
                            o_dst_ip, o_src_port, o_dst_port, o_udp_data_len, o_rd_data}), 64'd0);
    rd(8'h00, 32'h00000202);
    rd(8'h01, 32'h0);
    rd(8'h02, 32'h0);

    // 2. commit + send UDP on ch0, latency and hold
    wr(8'h2E, 32'hC0A80001);
    wr(8'h33, 32'd64);
    wr(8'h20, 32'h12);
    chk("lat_pending_only", 64'(o_req), 64'd0);
    step(1);
    chk("grant0", 64'({o_req, o_req_ch, o_req_type, o_src_ip, o_udp_data_len}),
        64'({1'b1, 3'd0, 2'd2, 32'hC0A80001, 16'd64}));
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold0", 64'({o_req, o_req_ch, o_req_type, o_src_ip, o_udp_data_len}),
          64'({1'b1, 3'd0, 2'd2, 32'hC0A80001, 16'd64}));
    end
    rd(8'h02, 32'h1);
    rd(8'h20, 32'h0);
    ack();
    chk("ack_drop", 64'(o_req), 64'd0);
    rd(8'h02, 32'h0);

    // 3. shadow isolation on ch1
    wr(8'h51, 32'd5000);
    wr(8'h40, 32'h01);
    wait_req("req_ch1");
    chk("grant1_arp", 64'({o_req_ch, o_req_type, o_dst_port, o_src_ip}),
        64'({3'd1, 2'd1, 16'd0, 32'd0}));
    rd(8'h51, 32'd5000);
    rd(8'h02, 32'h2);
    ack();

    // 4. round robin
    wr(8'h20, 32'h02);
    wr(8'h40, 32'h02);
    wait_req("rr_a");
    chk("rr_first_ch0", 64'({o_req_ch, o_req_type}), 64'({3'd0, 2'd2}));
    rd(8'h02, 32'h3);
    ack();
    wait_req("rr_b");
    chk("rr_second_ch1", 64'({o_req_ch, o_req_type}), 64'({3'd1, 2'd2}));
    ack();
    wr(8'h40, 32'h01);
    wr(8'h20, 32'h01);
    wait_req("rr_c");
    chk("rr2_first_ch1", 64'({o_req_ch, o_req_type}), 64'({3'd1, 2'd1}));
    ack();
    wait_req("rr_d");
    chk("rr2_second_ch0", 64'({o_req_ch, o_req_type}), 64'({3'd0, 2'd1}));
    ack();

    // 5. overflow
    wr(8'h20, 32'h02);
    wr(8'h20, 32'h01);
    wait_req("ovf_req");
    chk("ovf_grant", 64'({o_req_ch, o_req_type, o_overflow}), 64'({3'd0, 2'd2, 2'b01}));
    rd(8'h01, 32'h1);
    ack();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (o_req) seen = 1;
    end
    chk("ovf_single_grant", 64'(seen), 64'd0);
    wr(8'h01, 32'h0);
    chk("ovf_keep", 64'(o_overflow), 64'd1);
    wr(8'h01, 32'h1);
    chk("ovf_clear", 64'(o_overflow), 64'd0);
    rd(8'h01, 32'h0);

    // 6. deferred commit with re-arm
    wr(8'h20, 32'h02);
    wait_req("dc_req");
    chk("dc_before", 64'({o_req_ch, o_src_port}), 64'({3'd0, 16'd0}));
    wr(8'h30, 32'h1234);
    wr(8'h20, 32'h10);
    wr(8'h30, 32'h5678);
    wr(8'h20, 32'h10);
    step(2);
    chk("dc_frozen", 64'({o_req, o_src_port, o_src_ip}), 64'({1'b1, 16'd0, 32'hC0A80001}));
    rd(8'h30, 32'h5678);
    ack();
    wr(8'h20, 32'h02);
    wait_req("dc_req2");
    chk("dc_after", 64'({o_req_ch, o_src_port}), 64'({3'd0, 16'h5678}));
    ack();

    // ack in IDLE is ignored
    ack();
    step(2);
    chk("idle_ack", 64'(o_req), 64'd0);
    rd(8'h02, 32'h0);

    // register table on ch1 and global window
    for (int i = 0; i < 20; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, vecs[i].rexp);
    end

    // same-cycle read and write returns old value
    rdwr(8'h4E, 32'h01020304, 32'h0);
    rd(8'h4E, 32'h01020304);

    // full field mapping through a commit+BOTH grant on ch1
    wr(8'h40, 32'h13);
    wait_req("map_req");
    chk("map_ctrl", 64'({o_req_ch, o_req_type, o_operation}), 64'({3'd1, 2'd3, 2'd2}));
    chk("map_src_mac", 64'(o_src_mac), 64'h0000DEADBEEF1234);
    chk("map_dst_mac", 64'(o_dst_mac), 64'h000001020304ABCD);
    chk("map_ips", 64'({o_src_ip, o_dst_ip}), 64'h010203040A000001);
    chk("map_ports", 64'({o_src_port, o_dst_port, o_udp_data_len}), 64'h0000AAAA555505DC);
    chk("map_tha", 64'(o_THA), 64'h0000112233445566);
    chk("map_sha", 64'(o_SHA), 64'h0000998877667788);
    chk("map_pa", 64'({o_TPA, o_SPA}), 64'hC0A801020A0A0A0A);

    // reset mid-handshake
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_ctrl", 64'({o_req, o_req_ch, o_req_type, o_overflow, o_operation}), 64'd0);
    chk("mid_rst_fields", 64'(|{o_dst_mac, o_src_mac, o_SHA, o_THA, o_SPA, o_TPA, o_src_ip,
                                o_dst_ip, o_src_port, o_dst_port, o_udp_data_len}), 64'd0);
    rd(8'h4A, 32'h0);
    rd(8'h02, 32'h0);

    step(3);
    chk("rd_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_regs_mc.md
Name: cmd_regs_mc

Overview:
Multi-channel command register bank and the next generation of the single-channel packet-config block. It holds N_CH independent Ethernet/ARP/IPv4/UDP header configurations, written by the host command bus into shadow registers and committed atomically to active registers. A round-robin arbiter queues per-channel send requests and presents one channel's active configuration to the packet engine over a req/ack handshake. Registers are read back through the same bus.

Parameters:
N_CH, 2, number of channels (1..7).
ADDR_W, 8, command address width. Window w = addr[ADDR_W-1:5]; offset = addr[4:0].
VERSION, 8'h02, value returned in the global ID register.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
i_cmd_addr  in  ADDR_W  command address
i_cmd_data  in  32  write data
i_cmd_wr  in  1  write strobe, one cycle per write
i_cmd_rd  in  1  read strobe
o_rd_data  out  32  read data, valid with o_rd_valid
o_rd_valid  out  1  one-cycle pulse, one cycle after i_cmd_rd
o_req  out  1  send request to packet engine
o_req_ch  out  3  granted channel
o_req_type  out  2  packet type: 1=ARP, 2=UDP, 3=ARP then UDP
i_ack  in  1  engine has finished the granted packet
o_dst_mac, o_src_mac  out  48  Ethernet MACs of granted channel
o_operation  out  2  ARP operation
o_SHA, o_THA  out  48  ARP sender/target MAC
o_SPA, o_TPA  out  32  ARP sender/target IP
o_src_ip, o_dst_ip  out  32  IPv4 addresses
o_src_port, o_dst_port  out  16  UDP ports
o_udp_data_len  out  16  UDP payload length
o_overflow  out  N_CH  sticky per-channel overflow flags

Behaviour:
- Address map. Window 0 is global; window c+1 is channel c. Writes or reads to channel windows with c >= N_CH are ignored, and reads return 0.
- Global offsets:
  - 0: read-only, {16'd0, N_CH[7:0], VERSION}.
  - 1: status. Read returns overflow[N_CH-1:0]. A write with bit0=1 clears all overflow flags.
  - 2: read-only pending mask.
- Channel offsets write shadow registers:
  - 10/11: src_mac[47:16] / [15:0]
  - 12/13: dst_mac hi / lo
  - 14: src_ip; 15: dst_ip
  - 16: src_port; 17: dst_port
  - 18: {src_port, dst_port}
  - 19: udp_data_len
  - 20: operation[1:0]
  - 21/22: THA hi / lo; 23: TPA
  - 24/25: SHA hi / lo; 26: SPA
  - Reads of these offsets return shadow values, zero-extended. Unmapped offsets read 0.
- Channel offset 0 is control (write-only; reads 0):
  - bit4 = commit: active[c] <= shadow[c] on the next edge.
  - bits[1:0] != 0 = send request of that type.
  - Commit and send in the same write: the send uses the newly committed values.
- Commit while channel c is granted (state REQ and o_req_ch == c):
  - The active copy stays frozen and commit_pend[c] is set.
  - The commit is applied on the cycle i_ack completes that grant.
  - A further commit while deferred simply re-arms; the latest shadow is copied on ack.
- Send request handling:
  - If pending[c] is 0 and c is not granted: pending[c] <= 1 and type[c] <= bits[1:0].
  - Otherwise the request is dropped, the existing request is unchanged, and overflow[c] <= 1 (sticky).
- Arbiter FSM:
  - IDLE: if pending != 0, select the first pending channel at or after rr_ptr (wrapping modulo N_CH). Register its active config onto the o_* field outputs plus o_req_ch/o_req_type, set o_req=1, go to REQ.
  - REQ: all outputs stay stable until i_ack. When i_ack is sampled high: o_req <= 0, pending[ch] <= 0, rr_ptr <= ch+1 (mod N_CH), apply any deferred commit, go to IDLE.
  - At least one IDLE cycle separates grants. Request-to-o_req latency is 2 cycles (pending set, then grant).
  - i_ack while in IDLE is ignored.
- Readback: o_rd_data and o_rd_valid are registered, with 1-cycle latency. A same-cycle read and write to the same register returns the old value.
- Reset (synchronous, rst=1): all shadow, active, pending, commit_pend and overflow registers clear to 0; rr_ptr=0; state IDLE; o_req=0; o_rd_valid=0; every output is 0. Reset mid-handshake drops the grant, and the engine must treat o_req falling as an abort.

Decomposition:
- Package cmd_regs_pkg holds:
  - the offset constants (OFS_CTRL=0 … OFS_SPA=26, GOFS_ID/STATUS/PEND);
  - pkt_type_t (NONE, ARP, UDP, BOTH);
  - chan_cfg_t, a packed struct of all header fields, used for both shadow and active arrays.
- One sub-module, cmd_rr_arbiter, takes a pending mask and rr_ptr and returns grant index and valid. It is combinational and parametrised by N_CH.

Test Plan:
1. Reset, then read global 0 -> 0x00000202 for N_CH=2; all outputs 0; o_req=0.
2. Ch0: write src_ip=0xC0A80001 (addr 0x2E), udp_len=64, commit+send UDP (addr 0x20, data 0x12). Expect: o_req high 2 cycles later, o_req_ch=0, o_req_type=2, o_src_ip=C0A80001, o_udp_data_len=64. Hold i_ack low 10 cycles -> outputs stable.
3. Shadow isolation: ch1 write dst_port=5000 without commit, then send ARP -> granted o_dst_port=0 (active); readback of addr 0x51 returns 5000.
4. Round robin: send on both channels in the same burst with rr_ptr=0. Grants go ch0 then ch1; with immediate acks the next round, started with ch1 pending, grants ch1 first.
5. Overflow: send ch0 twice before ack -> overflow[0]=1, single grant with the first type. Write global 1 with data 1 -> flag clears.
6. Deferred commit: while ch0 is granted, change src_port and commit. The granted output is unchanged until i_ack; the next ch0 grant shows the new port.
